dcache_responder: RTL and testbench

- Memory-side responder for the execute stage's data-cache request bus. Accepts one load or store per cycle (word index plus byte offset) and performs byte-lane stores into a 2^CACHE_DEEPTHE x 32 SRAM.
- Returns aligned, sign- or zero-extended load data one cycle after acceptance.
- After every reset, runs a self-clear sweep of the array before accepting requests.
- Feeds load results into the Mem1 result-select path.

---
 rtl/dcache_responder.sv | 174 +++++++++++++++++
 tb/tb_dcache_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Memory-side responder for the data-cache request bus: byte-lane stores into a
// 2^CACHE_DEEPTHE x 32 array, extended load data one cycle after acceptance.
module dcache_responder #(
    parameter int CACHE_WIDTHE  = 5,
    parameter int CACHE_DEEPTHE = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iReqValid,
    output logic                     oReqReady,
    input  logic                     iReqWrite,
    input  logic [CACHE_DEEPTHE-1:0] iAddr,
    input  logic [1:0]               iMemAddr,
    input  logic [1:0]               iSize,
    input  logic                     iUnsigned,
    input  logic [31:0]              iWrData,
    output logic                     oRspValid,
    output logic [31:0]              oRspData,
    output logic                     oMisalign
);

    generate
        if (CACHE_WIDTHE != 5) begin : g_bad_width
            $error("dcache_responder: only CACHE_WIDTHE=5 (32-bit data) is supported");
        end
    endgenerate

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [31:0] mem_q [0:(1 << CACHE_DEEPTHE)-1];

    logic [0:0]               state_q, state_d;
    logic [CACHE_DEEPTHE-1:0] cnt_q, cnt_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     misalign_q, misalign_d;
    logic                     is_load_q, is_load_d;
    logic [1:0]               offset_q, offset_d;
    logic [1:0]               size_q, size_d;
    logic                     unsigned_q, unsigned_d;
    logic [31:0]              rd_word_q, rd_word_d;

    logic                     accept;
    logic                     misaligned;
    logic [3:0]               req_be;
    logic [31:0]              req_wdata;

    logic                     mem_we;
    logic [CACHE_DEEPTHE-1:0] mem_addr;
    logic [3:0]               mem_be;
    logic [31:0]              mem_wdata;

    assign oReqReady = (state_q == ST_RUN);
    assign accept    = iReqValid & oReqReady;

    always_comb begin
        misaligned = 1'b0;
        req_be     = 4'b0000;
        req_wdata  = iWrData;
        case (iSize)
            SZ_BYTE: begin
                req_be    = 4'b0001 << iMemAddr;
                req_wdata = {4{iWrData[7:0]}};
            end
            SZ_HALF: begin
                misaligned = iMemAddr[0];
                req_be     = iMemAddr[1] ? 4'b1100 : 4'b0011;
                req_wdata  = {2{iWrData[15:0]}};
            end
            SZ_WORD: begin
                misaligned = |iMemAddr;
                req_be     = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // The clear sweep and request stores share the single array write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = iAddr;
        mem_be    = req_be;
        mem_wdata = req_wdata;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end else if (accept && iReqWrite && !misaligned) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end

        rsp_valid_d = accept;
        misalign_d  = accept & misaligned;
        is_load_d   = accept & ~iReqWrite & ~misaligned;
        offset_d    = accept ? iMemAddr  : offset_q;
        size_d      = accept ? iSize     : size_q;
        unsigned_d  = accept ? iUnsigned : unsigned_q;
        rd_word_d   = (accept && !iReqWrite) ? mem_q[iAddr] : rd_word_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            is_load_q   <= 1'b0;
            offset_q    <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            rd_word_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            misalign_q  <= misalign_d;
            is_load_q   <= is_load_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            rd_word_q   <= rd_word_d;
        end
    end

    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    always_comb begin
        rsp_byte = rd_word_q[{offset_q, 3'b000} +: 8];
        rsp_half = offset_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        oRspData = '0;
        if (is_load_q) begin
            case (size_q)
                SZ_BYTE: oRspData = unsigned_q ? {24'h0, rsp_byte}
                                               : {{24{rsp_byte[7]}}, rsp_byte};
                SZ_HALF: oRspData = unsigned_q ? {16'h0, rsp_half}
                                               : {{16{rsp_half[15]}}, rsp_half};
                default: oRspData = rd_word_q;
            endcase
        end
    end

    assign oRspValid = rsp_valid_q;
    assign oMisalign = misalign_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a 16-word array: clear sweep, store
// lane merging, load extension, misalignment, back-to-back and mid-run reset.
module tb_dcache_responder;

    localparam int DEPTH_BITS = 4;
    localparam int DEPTH      = 1 << DEPTH_BITS;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  iReqValid = 1'b0;
    logic                  oReqReady;
    logic                  iReqWrite = 1'b0;
    logic [DEPTH_BITS-1:0] iAddr = '0;
    logic [1:0]            iMemAddr = '0;
    logic [1:0]            iSize = '0;
    logic                  iUnsigned = 1'b0;
    logic [31:0]           iWrData = '0;
    logic                  oRspValid;
    logic [31:0]           oRspData;
    logic                  oMisalign;

    int nvec = 0;
    int nerr = 0;

    dcache_responder #(.CACHE_WIDTHE(5), .CACHE_DEEPTHE(DEPTH_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .iReqValid (iReqValid),
        .oReqReady (oReqReady),
        .iReqWrite (iReqWrite),
        .iAddr     (iAddr),
        .iMemAddr  (iMemAddr),
        .iSize     (iSize),
        .iUnsigned (iUnsigned),
        .iWrData   (iWrData),
        .oRspValid (oRspValid),
        .oRspData  (oRspData),
        .oMisalign (oMisalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic wr, input int unsigned idx,
                       input logic [1:0] off, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
        iReqValid = v;
        iReqWrite = wr;
        iAddr     = idx[DEPTH_BITS-1:0];
        iMemAddr  = off;
        iSize     = sz;
        iUnsigned = uns;
        iWrData   = wd;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic rsp(input string tag, input logic v, input logic [31:0] d, input logic m);
        check({tag, ".valid"}, {31'h0, oRspValid}, {31'h0, v});
        check({tag, ".data"},  oRspData, d);
        check({tag, ".mis"},   {31'h0, oMisalign}, {31'h0, m});
    endtask

    // Releases rst and checks ready stays low for exactly DEPTH cycles while a
    // load of word 9 is held on the bus and ignored.
    task automatic release_and_sweep(input string tag);
        req(1'b1, 1'b0, 9, 2'd0, 2'b10, 1'b0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check({tag, ".init_ready"}, {31'h0, oReqReady}, 32'h0);
            check({tag, ".init_valid"}, {31'h0, oRspValid}, 32'h0);
            tick();
        end
        check({tag, ".run_ready"}, {31'h0, oReqReady}, 32'h1);
        tick();
        rsp({tag, ".ld9"}, 1'b1, 32'h0000_0000, 1'b0);
    endtask

    initial begin
        tick();
        tick();
        check("rst.ready", {31'h0, oReqReady}, 32'h0);
        rsp("rst", 1'b0, 32'h0, 1'b0);

        release_and_sweep("sweep1");

        req(1'b1, 1'b1, 3, 2'd0, 2'b10, 1'b0, 32'hDEAD_BEEF); tick();
        rsp("st3", 1'b1, 32'h0, 1'b0);
        req(1'b1, 1'b0, 3, 2'd3, 2'b00, 1'b0, 32'h0); tick();
        rsp("ldb3s", 1'b1, 32'hFFFF_FFDE, 1'b0);
        req(1'b1, 1'b0, 3, 2'd3, 2'b00, 1'b1, 32'h0); tick();
        rsp("ldb3u", 1'b1, 32'h0000_00DE, 1'b0);

        req(1'b1, 1'b1, 5, 2'd0, 2'b10, 1'b0, 32'h1122_3344); tick();
        req(1'b1, 1'b1, 5, 2'd2, 2'b01, 1'b0, 32'h0000_8001); tick();
        rsp("sth5", 1'b1, 32'h0, 1'b0);
        req(1'b1, 1'b0, 5, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("ldw5", 1'b1, 32'h8001_3344, 1'b0);
        req(1'b1, 1'b0, 5, 2'd2, 2'b01, 1'b0, 32'h0); tick();
        rsp("ldh5s", 1'b1, 32'hFFFF_8001, 1'b0);
        req(1'b1, 1'b0, 5, 2'd0, 2'b01, 1'b1, 32'h0); tick();
        rsp("ldh5u", 1'b1, 32'h0000_3344, 1'b0);
        req(1'b1, 1'b0, 5, 2'd1, 2'b00, 1'b0, 32'h0); tick();
        rsp("ldb5o1", 1'b1, 32'h0000_0033, 1'b0);
        req(1'b1, 1'b0, 5, 2'd3, 2'b00, 1'b0, 32'h0); tick();
        rsp("ldb5o3", 1'b1, 32'hFFFF_FF80, 1'b0);

        req(1'b1, 1'b0, 5, 2'd1, 2'b10, 1'b0, 32'h0); tick();
        rsp("misw", 1'b1, 32'h0, 1'b1);
        req(1'b1, 1'b0, 5, 2'd3, 2'b01, 1'b0, 32'h0); tick();
        rsp("mish", 1'b1, 32'h0, 1'b1);
        req(1'b1, 1'b0, 5, 2'd0, 2'b11, 1'b0, 32'h0); tick();
        rsp("missz", 1'b1, 32'h0, 1'b1);
        req(1'b1, 1'b1, 5, 2'd2, 2'b10, 1'b0, 32'hFFFF_FFFF); tick();
        rsp("misst", 1'b1, 32'h0, 1'b1);
        req(1'b1, 1'b1, 5, 2'd1, 2'b01, 1'b0, 32'hFFFF_FFFF); tick();
        req(1'b1, 1'b0, 5, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("ldw5keep", 1'b1, 32'h8001_3344, 1'b0);

        req(1'b1, 1'b1, 3, 2'd2, 2'b00, 1'b0, 32'h1234_5655); tick();
        req(1'b1, 1'b0, 3, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("ldw3lane", 1'b1, 32'hDE55_BEEF, 1'b0);

        req(1'b1, 1'b1, 7, 2'd0, 2'b00, 1'b0, 32'h0000_00AA); tick();
        rsp("b2b.st", 1'b1, 32'h0, 1'b0);
        req(1'b1, 1'b0, 7, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("b2b.ld", 1'b1, 32'h0000_00AA, 1'b0);
        idle(); tick();
        rsp("idle", 1'b0, 32'h0, 1'b0);

        req(1'b1, 1'b0, 3, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("pre_rst", 1'b1, 32'hDE55_BEEF, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst.ready", {31'h0, oReqReady}, 32'h0);
        rsp("midrst", 1'b0, 32'h0, 1'b0);
        tick();
        rsp("midrst_hold", 1'b0, 32'h0, 1'b0);

        release_and_sweep("sweep2");
        req(1'b1, 1'b0, 3, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("lost3", 1'b1, 32'h0, 1'b0);
        req(1'b1, 1'b0, 7, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("lost7", 1'b1, 32'h0, 1'b0);
        req(1'b1, 1'b0, 5, 2'd0, 2'b10, 1'b0, 32'h0); tick();
        rsp("lost5", 1'b1, 32'h0, 1'b0);
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
